// File: rtl/lcd_sequencer.sv
// lcd_sequencer: walks the character/instruction word store and drives an
// HD44780-style 8-bit LCD bus. It plays words 0..NUM_WORDS-1 once after
// power-up, then refreshes LOOP_ADDR..NUM_WORDS-1 forever.
//
// state   | meaning
// --------+-------------------------------------------------------------
// POWERUP | LCD power-on settle time after reset
// FETCH   | latch {RS, DATA} of the word at addr (one cycle)
// SETUP   | RS/DATA stable, E low, before the enable strobe
// PULSE   | E high
// WAIT    | E low, LCD executing the word (longer for clear/home)
// REFRESH | idle gap between refresh passes, busy low
module lcd_sequencer #(
  parameter int NUM_WORDS         = 9,
  parameter int LOOP_ADDR         = 4,
  parameter int POWERUP_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 2,
  parameter int E_HIGH_CYCLES     = 12,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int REFRESH_CYCLES    = 2500000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [8:0] rd_data_i,
  output logic [5:0] addr_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  // One shared down-counter, wide enough for the longest interval.
  localparam int MAX_A   = (POWERUP_CYCLES > REFRESH_CYCLES) ? POWERUP_CYCLES : REFRESH_CYCLES;
  localparam int MAX_B   = (CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_C   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWR_LD   = cnt_t'(POWERUP_CYCLES - 1);
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t EHI_LD   = cnt_t'(E_HIGH_CYCLES - 1);
  localparam cnt_t CMD_LD   = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t CLR_LD   = cnt_t'(CLEAR_WAIT_CYCLES - 1);
  localparam cnt_t REF_LD   = cnt_t'(REFRESH_CYCLES - 1);

  localparam logic [5:0] LAST_ADDR = 6'(NUM_WORDS - 1);
  localparam logic [5:0] LOOP_A    = 6'(LOOP_ADDR);

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    FETCH   = 3'd1,
    SETUP   = 3'd2,
    PULSE   = 3'd3,
    WAIT    = 3'd4,
    REFRESH = 3'd5
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       e_q, e_d;
  logic       fd_q, fd_d;
  logic       cnt_zero;
  logic       is_clear;

  assign cnt_zero = (cnt_q == '0);
  // Clear display (0x01) and return home (0x02) need the long execution wait.
  assign is_clear = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

  // State, counter, address and word-latch registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= POWERUP;
      cnt_q   <= PWR_LD;
      addr_q  <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic: every timed state counts down and acts at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rs_d    = rs_q;
    e_d     = e_q;
    fd_d    = 1'b0;
    case (state_q)
      POWERUP: begin
        if (cnt_zero) state_d = FETCH;
        else          cnt_d   = cnt_q - cnt_t'(1);
      end
      FETCH: begin
        rs_d    = rd_data_i[8];
        data_d  = rd_data_i[7:0];
        cnt_d   = SETUP_LD;
        state_d = SETUP;
      end
      SETUP: begin
        if (cnt_zero) begin
          e_d     = 1'b1;
          cnt_d   = EHI_LD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          e_d     = 1'b0;
          cnt_d   = is_clear ? CLR_LD : CMD_LD;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          if (addr_q == LAST_ADDR) begin
            fd_d    = 1'b1;
            addr_d  = LOOP_A;
            cnt_d   = REF_LD;
            state_d = REFRESH;
          end else begin
            addr_d  = addr_q + 6'd1;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      REFRESH: begin
        if (cnt_zero) state_d = FETCH;
        else          cnt_d   = cnt_q - cnt_t'(1);
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = PWR_LD;
      end
    endcase
  end

  assign addr_o       = addr_q;
  assign lcd_data_o   = data_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = 1'b0;
  assign lcd_e_o      = e_q;
  assign busy_o       = (state_q != REFRESH);
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with shrunk timing parameters.
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] rd_data;
  logic [5:0] addr;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, frame_done;

  logic [8:0] mem [0:63];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[addr];

  lcd_sequencer #(
    .NUM_WORDS(9), .LOOP_ADDR(4), .POWERUP_CYCLES(10), .SETUP_CYCLES(2),
    .E_HIGH_CYCLES(3), .CMD_WAIT_CYCLES(5), .CLEAR_WAIT_CYCLES(20), .REFRESH_CYCLES(30)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rd_data_i(rd_data), .addr_o(addr),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_e_o(lcd_e),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  // Bus monitor: records every E pulse and flags bus-rule violations.
  int         cyc, last_fall, ev_n, width_cur, fd_n, busy_low, rw_bad, stab_bad, addr_max;
  logic       prev_e;
  logic [8:0] h1, h2, cur_word;
  int         ev_rise [32];
  int         ev_gap  [32];
  int         ev_w    [32];
  logic [8:0] ev_word [32];
  logic [5:0] ev_addr [32];

  initial begin
    rw_bad = 0; stab_bad = 0; h1 = '0; h2 = '0; cur_word = '0;
    cyc = 0; last_fall = 0; ev_n = 0; width_cur = 0; fd_n = 0; busy_low = 0;
    addr_max = 0; prev_e = 1'b0;
  end

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (rst) begin
      cyc = 0; last_fall = 0; ev_n = 0; width_cur = 0; fd_n = 0;
      busy_low = 0; addr_max = 0; prev_e = 1'b0;
    end else begin
      cyc++;
      if (int'(addr) > addr_max) addr_max = int'(addr);
      if (frame_done === 1'b1) fd_n++;
      if (busy === 1'b0) busy_low++;
      if (lcd_e === 1'b1 && !prev_e) begin
        cur_word = {lcd_rs, lcd_data};
        if (ev_n < 32) begin
          ev_rise[ev_n] = cyc;
          ev_gap[ev_n]  = cyc - last_fall;
          ev_word[ev_n] = cur_word;
          ev_addr[ev_n] = addr;
          ev_w[ev_n]    = 0;
        end
        if (h1 !== cur_word || h2 !== cur_word) stab_bad++;
        width_cur = 1;
        ev_n++;
      end else if (lcd_e === 1'b1) begin
        width_cur++;
        if ({lcd_rs, lcd_data} !== cur_word) stab_bad++;
      end else if (prev_e) begin
        if (ev_n >= 1 && ev_n <= 32) ev_w[ev_n-1] = width_cur;
        last_fall = cyc;
      end
      prev_e = lcd_e;
    end
    h2 = h1;
    h1 = {lcd_rs, lcd_data};
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_assert++; if (lcd_e !== 1'b0)      begin n_fail++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
    n_assert++; if (addr !== 6'd0)       begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    n_assert++; if (lcd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
    n_assert++; if (lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
    n_assert++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
  endtask

  task automatic test_first_word();
    mem[0] = 9'h120;
    rst = 1'b0;
    for (int k = 0; k < 100 && !(ev_n >= 1 && lcd_e === 1'b0); k++) begin
      @(negedge clk); #1;
    end
    n_assert++;
    if (!(ev_n >= 1 && lcd_e === 1'b0)) begin
      n_fail++; $display("FAIL first_timeout: got %0d pulses expected 1", ev_n);
    end else begin
      n_assert++; if (ev_rise[0] != 13)     begin n_fail++; $display("FAIL first_rise: got %0d expected 13", ev_rise[0]); end
      n_assert++; if (ev_addr[0] !== 6'd0)  begin n_fail++; $display("FAIL first_addr: got %0d expected 0", ev_addr[0]); end
      n_assert++; if (ev_word[0] !== 9'h120) begin n_fail++; $display("FAIL first_word: got %h expected 120", ev_word[0]); end
      n_assert++; if (ev_w[0] != 3)         begin n_fail++; $display("FAIL first_width: got %0d expected 3", ev_w[0]); end
    end
  endtask

  task automatic test_full_pass();
    logic [8:0] words [9];
    logic [8:0] exp_word;
    int         idx, exp_gap;
    logic       chg;
    words = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h12D, 9'h132, 9'h135, 9'h130};
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    for (int i = 0; i < 9; i++) mem[i] = words[i];
    rst = 1'b0;
    chg = 1'b0;
    for (int k = 0; k < 2000 && !(ev_n >= 14 && lcd_e === 1'b0); k++) begin
      @(negedge clk); #1;
      if (!chg && lcd_e === 1'b1 && addr === 6'd6) begin
        mem[6] = 9'h137;
        chg = 1'b1;
      end
    end
    n_assert++;
    if (!(ev_n >= 14 && lcd_e === 1'b0)) begin
      n_fail++; $display("FAIL pass_timeout: got %0d pulses expected 14", ev_n);
    end else begin
      for (int j = 0; j < 14; j++) begin
        idx = (j < 9) ? j : j - 5;
        exp_word = words[idx];
        if (j >= 9 && idx == 6) exp_word = 9'h137;
        if (j == 0)      exp_gap = 13;
        else if (j == 9) exp_gap = 5 + 30 + 1 + 2;
        else             exp_gap = ((words[idx-1] == 9'h001) ? 20 : 5) + 1 + 2;
        n_assert++; if (ev_word[j] !== exp_word)   begin n_fail++; $display("FAIL pulse%0d_word: got %h expected %h", j, ev_word[j], exp_word); end
        n_assert++; if (ev_addr[j] !== 6'(idx))    begin n_fail++; $display("FAIL pulse%0d_addr: got %0d expected %0d", j, ev_addr[j], idx); end
        n_assert++; if (ev_w[j] != 3)              begin n_fail++; $display("FAIL pulse%0d_width: got %0d expected 3", j, ev_w[j]); end
        n_assert++; if (ev_gap[j] != exp_gap)      begin n_fail++; $display("FAIL pulse%0d_gap: got %0d expected %0d", j, ev_gap[j], exp_gap); end
      end
      n_assert++; if (fd_n != 1)      begin n_fail++; $display("FAIL frame_done_cycles: got %0d expected 1", fd_n); end
      n_assert++; if (busy_low != 30) begin n_fail++; $display("FAIL busy_low_cycles: got %0d expected 30", busy_low); end
      n_assert++; if (addr_max != 8)  begin n_fail++; $display("FAIL addr_max: got %0d expected 8", addr_max); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    for (int k = 0; k < 500 && !(lcd_e === 1'b1 && addr === 6'd6); k++) begin
      @(negedge clk); #1;
    end
    n_assert++;
    if (!(lcd_e === 1'b1 && addr === 6'd6)) begin
      n_fail++; $display("FAIL mid_timeout: got e=%b addr=%0d expected e=1 addr=6", lcd_e, addr);
    end else begin
      n_assert++; if (lcd_data !== 8'h37) begin n_fail++; $display("FAIL pass3_word6: got %h expected 37", lcd_data); end
      rst = 1'b1;
      @(negedge clk); #1;
      n_assert++; if (lcd_e !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_e: got %b expected 0", lcd_e); end
      n_assert++; if (addr !== 6'd0)      begin n_fail++; $display("FAIL mid_rst_addr: got %0d expected 0", addr); end
      n_assert++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h expected 00", lcd_data); end
      rst = 1'b0;
      for (int k = 0; k < 100 && !(ev_n >= 1 && lcd_e === 1'b0); k++) begin
        @(negedge clk); #1;
      end
      n_assert++;
      if (!(ev_n >= 1 && lcd_e === 1'b0)) begin
        n_fail++; $display("FAIL replay_timeout: got %0d pulses expected 1", ev_n);
      end else begin
        n_assert++; if (ev_rise[0] != 13)      begin n_fail++; $display("FAIL replay_rise: got %0d expected 13", ev_rise[0]); end
        n_assert++; if (ev_addr[0] !== 6'd0)   begin n_fail++; $display("FAIL replay_addr: got %0d expected 0", ev_addr[0]); end
        n_assert++; if (ev_word[0] !== 9'h038) begin n_fail++; $display("FAIL replay_word: got %h expected 038", ev_word[0]); end
      end
    end
  endtask

  task automatic test_bus_rules();
    n_assert++; if (rw_bad != 0)   begin n_fail++; $display("FAIL rw_low: got %0d bad cycles expected 0", rw_bad); end
    n_assert++; if (stab_bad != 0) begin n_fail++; $display("FAIL word_stable: got %0d bad cycles expected 0", stab_bad); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 9'h000;
    test_reset();
    test_first_word();
    test_full_pass();
    test_reset_mid_pulse();
    test_bus_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Reader side of the character/instruction register file: steps a 6-bit word address, fetches 9-bit words {RS, DATA[7:0]}, and drives an HD44780-style 8-bit LCD bus with correct enable timing.
- After power-up it plays words 0..NUM_WORDS-1 once: init commands, then the sign and digit characters.
- It then loops forever from LOOP_ADDR, so the display tracks the current temperature digits.

Parameters:
- NUM_WORDS, 9, words played per pass; addresses 0..NUM_WORDS-1.
- LOOP_ADDR, 4, first address of each refresh pass (the set-DDRAM-address command).
- POWERUP_CYCLES, 750000, idle cycles after reset before the first word (15 ms at 50 MHz).
- SETUP_CYCLES, 2, cycles RS/DATA are stable before E rises.
- E_HIGH_CYCLES, 12, E high width.
- CMD_WAIT_CYCLES, 2500, wait after E falls for a normal word (50 us).
- CLEAR_WAIT_CYCLES, 82000, wait after a clear/home command (1.64 ms).
- REFRESH_CYCLES, 2500000, gap between passes (50 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_Data  in  9  word at addr: bit 8 = RS, bits 7:0 = LCD byte; combinational w.r.t. addr
- addr  out  6  word address to the register file
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD R/W, tied to 0 (write only)
- lcd_e  out  1  LCD enable strobe
- busy  out  1  high whenever not in the REFRESH gap
- frame_done  out  1  one-cycle pulse when the last word of a pass completes its wait

Behaviour:
- States: POWERUP, FETCH, SETUP, PULSE, WAIT, REFRESH. One shared down-counter; its width is sized for the largest parameter.
- Reset (any state, any cycle; takes effect on the next edge): state=POWERUP, counter=POWERUP_CYCLES-1, addr=0, lcd_data=0, lcd_rs=0, lcd_e=0, frame_done=0, busy=1. Reset mid-pulse drops lcd_e on the next edge.
- POWERUP: count down to 0, then go to FETCH.
- FETCH (1 cycle): addr is already driven. Register lcd_rs<=rd_Data[8] and lcd_data<=rd_Data[7:0] into a word latch. Load counter=SETUP_CYCLES-1 and go to SETUP.
- The word latch holds lcd_rs/lcd_data constant from FETCH until the next FETCH. rd_Data changes outside FETCH are ignored.
- SETUP: at counter 0, set lcd_e=1, load E_HIGH_CYCLES-1 and go to PULSE.
- PULSE: lcd_e stays high for exactly E_HIGH_CYCLES cycles. At counter 0, set lcd_e=0 and load the wait count:
  - CLEAR_WAIT_CYCLES-1 if the latched RS=0 and the byte is 0x01 or 0x02;
  - else CMD_WAIT_CYCLES-1.
  - Then go to WAIT.
- WAIT, counter 0:
  - If addr==NUM_WORDS-1: pulse frame_done, set addr=LOOP_ADDR, load REFRESH_CYCLES-1, go to REFRESH.
  - Else: addr<=addr+1, go to FETCH.
- REFRESH: busy=0. At counter 0, go to FETCH; addr is already LOOP_ADDR.
- addr changes only on WAIT exit or reset. The new address is therefore stable at least 1 cycle before FETCH samples rd_Data.
- Address count saturates by construction: never exceeds NUM_WORDS-1, never wraps through 63.
- lcd_rw is constant 0.
- Per-word period: 1 + SETUP_CYCLES + E_HIGH_CYCLES + wait cycles.
- lcd_e rises SETUP_CYCLES cycles after the word latch updates.

Test Plan:
- Params shrunk (POWERUP=10, SETUP=2, E_HIGH=3, CMD_WAIT=5, CLEAR_WAIT=20, REFRESH=30). Release reset with rd_Data=9'h120 -> lcd_e stays 0 for 10 cycles, then first FETCH at addr=0; lcd_e high exactly 3 cycles with lcd_rs=1, lcd_data=0x20.
- Model file returns 0x038,0x00C,0x001,0x006,0x080 at 0..4 and 0x12D,0x132,0x135,0x130 at 5..8 -> nine E pulses in address order with those RS/DATA values. Gap after the 0x001 pulse is 20 cycles; gap after the others is 5 cycles.
- After addr 8 completes -> frame_done high 1 cycle, busy=0 for 30 cycles, next pulse is word 4 (0x080), then 5..8. Words 0..3 never replay.
- Change rd_Data at addr 6 from 0x132 to 0x137 during PULSE of that word -> lcd_data stays 0x32 for that pulse; the next pass shows 0x37.
- Assert rst for 1 cycle while lcd_e=1 during word 6 -> next edge lcd_e=0, addr=0, lcd_data=0. Full POWERUP delay elapses before word 0 replays.
- Check lcd_rw==0 in every cycle. Check lcd_rs/lcd_data are stable from SETUP through end of PULSE for every word.
